csr_stack_timer: RTL and testbench

CSR_STACK_TIMER -- requirements
Module: csr_stack_timer

---
 rtl/csr_stack_timer.sv | 147 ++++++++++++++
 tb/tb_csr_stack_timer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_stack_timer.sv
// rtl/csr_stack_timer.sv - general CSR, prescaled compare timer CSR and LIFO stack
// CSR reads return the pre-write value; the timer interrupt is sticky until cleared.
module csr_stack_timer #(
  parameter logic [11:0] CsrAddr    = 12'h350,
  parameter int          CsrWidth   = 5,
  parameter logic [11:0] TimerAddr  = 12'h400,
  parameter int          StackDepth = 8,
  parameter int          StackWidth = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                csr_enable,
  input  logic [11:0]                         csr_addr,
  input  logic [2:0]                          csr_op,
  input  logic [4:0]                          rs1_zimm,
  input  logic [31:0]                         rs1_data,
  input  logic [CsrWidth-1:0]                 ext_data,
  input  logic                                ext_write_enable,
  input  logic                                push,
  input  logic                                pop,
  input  logic [StackWidth-1:0]               stack_data_in,
  output logic [StackWidth-1:0]               stack_data_out,
  output logic [$clog2(StackDepth+1)-1:0]     stack_index_out,
  input  logic                                timer_interrupt_clear,
  output logic                                timer_interrupt_set,
  output logic [31:0]                         csr_direct_out,
  output logic [31:0]                         csr_out
);

  localparam int IdxW  = $clog2(StackDepth + 1);
  localparam int AddrW = (StackDepth > 1) ? $clog2(StackDepth) : 1;
  localparam logic [IdxW-1:0] FullIdx = IdxW'(StackDepth);
  localparam logic [31:0] TimerMask = 32'hF000_FFFF;

  logic [CsrWidth-1:0]   gen_csr;
  logic [31:0]           tmr_reg;
  logic [15:0]           pre_cnt;
  logic [15:0]           tmr_cnt;
  logic [15:0]           pre_mask;
  logic [3:0]            tmr_p;
  logic [15:0]           tmr_c;
  logic                  tick;
  logic                  match;
  logic                  irq;
  logic [StackWidth-1:0] stack_mem [StackDepth];
  logic [IdxW-1:0]       stack_idx;
  logic [IdxW-1:0]       top_idx;

  logic        gen_hit;
  logic        tmr_hit;
  logic [31:0] gen_val;
  logic [31:0] old_val;
  logic [31:0] operand;
  logic [31:0] wr_val;

  assign gen_val = 32'(gen_csr);
  assign gen_hit = csr_enable && (csr_op[1:0] != 2'b00) && (csr_addr == CsrAddr);
  assign tmr_hit = csr_enable && (csr_op[1:0] != 2'b00) && (csr_addr == TimerAddr);

  always_comb begin
    old_val = 32'h0;
    if (gen_hit) begin
      old_val = gen_val;
    end else if (tmr_hit) begin
      old_val = tmr_reg;
    end
    operand = csr_op[2] ? {27'h0, rs1_zimm} : rs1_data;
    case (csr_op[1:0])
      2'b01:   wr_val = operand;
      2'b10:   wr_val = old_val | operand;
      2'b11:   wr_val = old_val & ~operand;
      default: wr_val = old_val;
    endcase
  end

  assign csr_out        = old_val;
  assign csr_direct_out = gen_val;

  // Hardware write beats a same-cycle software write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen_csr <= '0;
    end else if (ext_write_enable) begin
      gen_csr <= ext_data;
    end else if (gen_hit) begin
      gen_csr <= wr_val[CsrWidth-1:0];
    end
  end

  assign tmr_p    = tmr_reg[31:28];
  assign tmr_c    = tmr_reg[15:0];
  assign pre_mask = (16'd1 << tmr_p) - 16'd1;
  assign tick     = (pre_cnt == pre_mask);
  assign match    = tick && (tmr_c != 16'h0) && (tmr_cnt == tmr_c);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_reg <= '0;
      pre_cnt <= '0;
      tmr_cnt <= '0;
    end else if (tmr_hit) begin
      tmr_reg <= wr_val & TimerMask;
      pre_cnt <= '0;
      tmr_cnt <= '0;
    end else begin
      pre_cnt <= tick ? 16'h0 : pre_cnt + 16'd1;
      if (tmr_c == 16'h0) begin
        tmr_cnt <= '0;
      end else if (tick) begin
        tmr_cnt <= match ? 16'h0 : tmr_cnt + 16'd1;
      end
    end
  end

  // A new match outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= match | (irq & ~timer_interrupt_clear);
    end
  end

  assign timer_interrupt_set = irq;

  assign top_idx = stack_idx - 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stack_idx <= '0;
      for (int i = 0; i < StackDepth; i++) begin
        stack_mem[i] <= '0;
      end
    end else if (push && pop && (stack_idx != '0)) begin
      stack_mem[top_idx[AddrW-1:0]] <= stack_data_in;
    end else if (push && (stack_idx < FullIdx)) begin
      stack_mem[stack_idx[AddrW-1:0]] <= stack_data_in;
      stack_idx <= stack_idx + 1'b1;
    end else if (pop && (stack_idx != '0)) begin
      stack_idx <= top_idx;
    end
  end

  assign stack_data_out  = (stack_idx == '0) ? '0 : stack_mem[top_idx[AddrW-1:0]];
  assign stack_index_out = stack_idx;

endmodule

// File: tb/tb_csr_stack_timer.sv
// tb/tb_csr_stack_timer.sv - randomized bench for csr_stack_timer against a behavioural model
module tb_csr_stack_timer;

  localparam logic [11:0] CSR_A = 12'h350;
  localparam logic [11:0] TMR_A = 12'h400;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_enable;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic [4:0]  rs1_zimm;
  logic [31:0] rs1_data;
  logic [4:0]  ext_data;
  logic        ext_write_enable;
  logic        push;
  logic        pop;
  logic [31:0] stack_data_in;
  logic [31:0] stack_data_out;
  logic [3:0]  stack_index_out;
  logic        timer_interrupt_clear;
  logic        timer_interrupt_set;
  logic [31:0] csr_direct_out;
  logic [31:0] csr_out;

  csr_stack_timer dut (
    .clk(clk), .reset(reset),
    .csr_enable(csr_enable), .csr_addr(csr_addr), .csr_op(csr_op),
    .rs1_zimm(rs1_zimm), .rs1_data(rs1_data),
    .ext_data(ext_data), .ext_write_enable(ext_write_enable),
    .push(push), .pop(pop), .stack_data_in(stack_data_in),
    .stack_data_out(stack_data_out), .stack_index_out(stack_index_out),
    .timer_interrupt_clear(timer_interrupt_clear),
    .timer_interrupt_set(timer_interrupt_set),
    .csr_direct_out(csr_direct_out), .csr_out(csr_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: timer events are found from elapsed cycles since the last timer write.
  logic [31:0] m_gen;
  logic [3:0]  m_p;
  logic [15:0] m_c;
  longint      m_n;
  bit          m_irq;
  logic [31:0] m_stack[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    csr_enable = 0; csr_addr = 12'h0; csr_op = 3'b000; rs1_zimm = 5'h0; rs1_data = 32'h0;
    ext_data = 5'h0; ext_write_enable = 0; push = 0; pop = 0; stack_data_in = 32'h0;
    timer_interrupt_clear = 0;
  endtask

  task automatic model_reset();
    m_gen = 0; m_p = 0; m_c = 0; m_n = 0; m_irq = 0;
    m_stack.delete();
  endtask

  function automatic logic [31:0] m_top();
    return (m_stack.size() == 0) ? 32'h0 : m_stack[m_stack.size()-1];
  endfunction

  task automatic step();
    bit hit_g, hit_t, ev;
    logic [31:0] oldv, opnd, newv;
    longint period;
    #1;
    hit_g = csr_enable && (csr_op[1:0] != 0) && (csr_addr == CSR_A);
    hit_t = csr_enable && (csr_op[1:0] != 0) && (csr_addr == TMR_A);
    oldv = hit_g ? m_gen : (hit_t ? {m_p, 12'h0, m_c} : 32'h0);
    check("csr_out", csr_out, oldv);
    check("csr_direct_out", csr_direct_out, m_gen);
    check("stack_top", stack_data_out, m_top());
    check("stack_index", 32'(stack_index_out), 32'(m_stack.size()));
    check("timer_irq", 32'(timer_interrupt_set), 32'(m_irq));
    @(posedge clk);
    opnd = csr_op[2] ? {27'h0, rs1_zimm} : rs1_data;
    case (csr_op[1:0])
      2'd1:    newv = opnd;
      2'd2:    newv = oldv | opnd;
      2'd3:    newv = oldv & ~opnd;
      default: newv = oldv;
    endcase
    ev = 0;
    if (m_c != 0) begin
      period = (longint'(m_c) + 1) * (longint'(1) << m_p);
      ev = ((m_n + 1) % period) == 0;
    end
    m_irq = ev || (m_irq && !timer_interrupt_clear);
    if (hit_t) begin
      m_p = newv[31:28]; m_c = newv[15:0]; m_n = 0;
    end else begin
      m_n++;
    end
    if (ext_write_enable) m_gen = 32'(ext_data);
    else if (hit_g) m_gen = newv & 32'h1F;
    if (push && pop && m_stack.size() > 0) m_stack[m_stack.size()-1] = stack_data_in;
    else if (push && m_stack.size() < 8) m_stack.push_back(stack_data_in);
    else if (pop && m_stack.size() > 0) void'(m_stack.pop_back());
    #1;
    set_idle();
  endtask

  task automatic csr_cmd(input logic [11:0] a, input logic [2:0] op, input logic [4:0] z,
                         input logic [31:0] d);
    csr_enable = 1; csr_addr = a; csr_op = op; rs1_zimm = z; rs1_data = d;
  endtask

  task automatic reset_now();
    reset = 0;
    #1;
    check("rst_index", 32'(stack_index_out), 32'h0);
    check("rst_top", stack_data_out, 32'h0);
    check("rst_direct", csr_direct_out, 32'h0);
    check("rst_irq", 32'(timer_interrupt_set), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  int r;

  initial begin
    set_idle();
    model_reset();
    reset = 0;
    #2;
    check("rst_index", 32'(stack_index_out), 32'h0);
    check("rst_direct", csr_direct_out, 32'h0);
    check("rst_irq", 32'(timer_interrupt_set), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;

    csr_cmd(CSR_A, 3'b101, 5'h1F, 32'h0); step();
    check("rwi_1f", csr_direct_out, 32'h1F);
    csr_cmd(CSR_A, 3'b110, 5'h00, 32'h0); #1;
    check("read_1f", csr_out, 32'h1F);
    step();
    csr_cmd(CSR_A, 3'b111, 5'h01, 32'h0); step();
    check("rci_1e", csr_direct_out, 32'h1E);
    csr_cmd(CSR_A, 3'b010, 5'h00, 32'hFFFF_FFE1); step();
    check("rs_trunc", csr_direct_out, 32'h1F);
    csr_cmd(CSR_A, 3'b001, 5'h00, 32'h3); ext_write_enable = 1; ext_data = 5'h10; step();
    check("ext_prio", csr_direct_out, 32'h10);

    csr_cmd(CSR_A, 3'b001, 5'h00, 32'h3); csr_enable = 0; #1;
    check("disabled_read", csr_out, 32'h0);
    step();
    csr_cmd(12'h123, 3'b001, 5'h00, 32'h3); #1;
    check("unmapped_read", csr_out, 32'h0);
    step();

    csr_cmd(TMR_A, 3'b001, 5'h00, 32'h0000_0003); step();
    for (int k = 1; k <= 4; k++) begin
      step();
      check("timer_rise", 32'(timer_interrupt_set), (k == 4) ? 32'h1 : 32'h0);
    end
    timer_interrupt_clear = 1; step();
    check("timer_clear", 32'(timer_interrupt_set), 32'h0);
    repeat (4) step();
    check("timer_rerise", 32'(timer_interrupt_set), 32'h1);
    csr_cmd(TMR_A, 3'b001, 5'h00, 32'h0); timer_interrupt_clear = 1; step();
    repeat (20) step();
    check("timer_c0", 32'(timer_interrupt_set), 32'h0);

    push = 1; stack_data_in = 32'hA; step();
    push = 1; stack_data_in = 32'hB; step();
    check("push2_idx", 32'(stack_index_out), 32'h2);
    check("push2_top", stack_data_out, 32'hB);
    pop = 1; step();
    check("pop_top", stack_data_out, 32'hA);
    push = 1; pop = 1; stack_data_in = 32'hC; step();
    check("pp_idx", 32'(stack_index_out), 32'h1);
    check("pp_top", stack_data_out, 32'hC);
    pop = 1; step();
    pop = 1; step();
    check("empty_idx", 32'(stack_index_out), 32'h0);
    check("empty_top", stack_data_out, 32'h0);

    for (int i = 0; i < 9; i++) begin
      push = 1; stack_data_in = 32'h100 + 32'(i); step();
    end
    check("full_idx", 32'(stack_index_out), 32'h8);
    check("full_top", stack_data_out, 32'h107);
    pop = 1; step();
    push = 1; stack_data_in = 32'h200; step();
    reset_now();

    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 15);
      csr_enable = ($urandom_range(0, 3) != 0);
      csr_addr = (r < 6) ? CSR_A : (r == 6) ? TMR_A : (r < 10) ? 12'h123 : 12'($urandom);
      csr_op = 3'($urandom);
      rs1_zimm = 5'($urandom);
      rs1_data = $urandom_range(0, 1) ? $urandom : ($urandom & 32'h3000_0007);
      ext_write_enable = ($urandom_range(0, 7) == 0);
      ext_data = 5'($urandom);
      push = ($urandom_range(0, 2) == 0);
      pop = ($urandom_range(0, 2) == 0);
      stack_data_in = $urandom;
      timer_interrupt_clear = ($urandom_range(0, 5) == 0);
      step();
      if (i == 500) reset_now();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
